// File: rtl/ones_gen_127.sv
// Sequential generator of a 127-bit word holding N consecutive ones starting at R,
// wrapping from bit 126 to bit 0; one bit is written per cycle.
module ones_gen_127 (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [6:0]   count,
   input  logic [6:0]   rot,
   output logic         busy,
   output logic         done,
   output logic [126:0] word,
   output logic [6:0]   pos
);

   localparam logic [6:0] LastPos = 7'd126;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StDone
   } state_e;

   state_e     state_q;
   logic [6:0] remaining_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         word        <= '0;
         pos         <= '0;
         remaining_q <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  word        <= '0;
                  // Position 127 does not exist in the word; treat it as 0.
                  pos         <= (rot == 7'd127) ? 7'd0 : rot;
                  remaining_q <= count;
                  if (count != 7'd0) begin
                     state_q <= StFill;
                     busy    <= 1'b1;
                  end else begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end
               end
            end
            StFill: begin
               word[pos]   <= 1'b1;
               remaining_q <= remaining_q - 7'd1;
               pos         <= (pos == LastPos) ? 7'd0 : pos + 7'd1;
               if (remaining_q == 7'd1) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
